// File: rtl/paint_cmd_sequencer_if.sv
// Signal bundle between the ASCII command decoder, the paint command
// sequencer, the framebuffer write port and the palette RAM.
interface paint_cmd_sequencer_if #(
  parameter int X_W = 6,
  parameter int Y_W = 6,
  parameter int C_W = 4
);

  logic                 cmd_valid;
  logic [3:0]           cmd_id;
  logic [6:0]           x;
  logic [6:0]           y;

  logic [X_W-1:0]       cur_x;
  logic [Y_W-1:0]       cur_y;
  logic [C_W-1:0]       cur_color;

  logic                 fb_req;
  logic [X_W+Y_W-1:0]   fb_addr;
  logic [C_W-1:0]       fb_data;
  logic                 fb_ack;

  logic                 pal_we;
  logic [C_W-1:0]       pal_addr;
  logic [6:0]           pal_data;

  logic                 busy;
  logic [7:0]           drop_cnt;
  logic [7:0]           err_cnt;

  // Sequencer side: takes commands and the framebuffer ack, drives everything else.
  modport master (
    input  cmd_valid, cmd_id, x, y, fb_ack,
    output cur_x, cur_y, cur_color, fb_req, fb_addr, fb_data,
           pal_we, pal_addr, pal_data, busy, drop_cnt, err_cnt
  );

  // Environment side: the decoder issuing commands and the memories answering.
  modport slave (
    output cmd_valid, cmd_id, x, y, fb_ack,
    input  cur_x, cur_y, cur_color, fb_req, fb_addr, fb_data,
           pal_we, pal_addr, pal_data, busy, drop_cnt, err_cnt
  );

endinterface

// File: rtl/paint_cmd_sequencer.sv
// Paint command sequencer: owns the cursor and current colour, executes
// decoded commands, runs single-pixel framebuffer writes over req/ack and
// strobes palette writes. A one-entry pending buffer catches a command that
// arrives while a write is outstanding; anything beyond that is counted as
// dropped.
module paint_cmd_sequencer #(
  parameter int X_W = 6,
  parameter int Y_W = 6,
  parameter int C_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  paint_cmd_sequencer_if.master bus
);

  localparam logic [3:0] CMD_UP    = 4'd1;
  localparam logic [3:0] CMD_DOWN  = 4'd2;
  localparam logic [3:0] CMD_LEFT  = 4'd3;
  localparam logic [3:0] CMD_RIGHT = 4'd4;
  localparam logic [3:0] CMD_ENT   = 4'd5;
  localparam logic [3:0] CMD_COL   = 4'd6;
  localparam logic [3:0] CMD_PAL   = 4'd7;

  localparam logic [X_W-1:0] X_ONE = {{(X_W-1){1'b0}}, 1'b1};
  localparam logic [Y_W-1:0] Y_ONE = {{(Y_W-1){1'b0}}, 1'b1};
  localparam logic [X_W-1:0] X_MAX = '1;
  localparam logic [Y_W-1:0] Y_MAX = '1;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t               state_q, state_d;

  logic [X_W-1:0]       curX_q, curX_d;
  logic [Y_W-1:0]       curY_q, curY_d;
  logic [C_W-1:0]       curColor_q, curColor_d;

  logic                 bufValid_q, bufValid_d;
  logic [3:0]           bufId_q, bufId_d;
  logic [6:0]           bufX_q, bufX_d;
  logic [6:0]           bufY_q, bufY_d;

  logic [X_W+Y_W-1:0]   fbAddr_q, fbAddr_d;
  logic [C_W-1:0]       fbData_q, fbData_d;

  logic                 palWe_q, palWe_d;
  logic [C_W-1:0]       palAddr_q, palAddr_d;
  logic [6:0]           palData_q, palData_d;

  logic                 busy_q, busy_d;
  logic [7:0]           dropCnt_q, dropCnt_d;
  logic [7:0]           errCnt_q, errCnt_d;

  logic                 execValid;
  logic [3:0]           execId;
  logic [6:0]           execX;
  logic [6:0]           execY;
  logic                 liveBlocked;
  logic                 unusedExecX;

  // Only the low colour-index bits of argument 1 are ever consumed.
  assign unusedExecX = ^execX[6:C_W];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pick the command to execute, decide buffering/dropping, and compute every next value.
  always_comb begin
    state_d    = state_q;
    curX_d     = curX_q;
    curY_d     = curY_q;
    curColor_d = curColor_q;
    bufValid_d = bufValid_q;
    bufId_d    = bufId_q;
    bufX_d     = bufX_q;
    bufY_d     = bufY_q;
    fbAddr_d   = fbAddr_q;
    fbData_d   = fbData_q;
    palWe_d    = 1'b0;
    palAddr_d  = palAddr_q;
    palData_d  = palData_q;
    dropCnt_d  = dropCnt_q;
    errCnt_d   = errCnt_q;
    execValid  = 1'b0;
    execId     = 4'd0;
    execX      = 7'd0;
    execY      = 7'd0;

    // The live command cannot run when a write is outstanding or the buffer has priority.
    liveBlocked = (state_q == WRITE) || bufValid_q;

    if (state_q == IDLE) begin
      if (bufValid_q) begin
        execValid  = 1'b1;
        execId     = bufId_q;
        execX      = bufX_q;
        execY      = bufY_q;
        bufValid_d = 1'b0;
      end else if (bus.cmd_valid) begin
        execValid = 1'b1;
        execId    = bus.cmd_id;
        execX     = bus.x;
        execY     = bus.y;
      end
    end else if (bus.fb_ack) begin
      state_d = IDLE;
    end

    // A blocked command fits in the buffer if it is empty or being drained right now.
    if (bus.cmd_valid && liveBlocked) begin
      if (!bufValid_q || (state_q == IDLE)) begin
        bufValid_d = 1'b1;
        bufId_d    = bus.cmd_id;
        bufX_d     = bus.x;
        bufY_d     = bus.y;
      end else if (dropCnt_q != 8'hFF) begin
        dropCnt_d = dropCnt_q + 8'd1;
      end
    end

    if (execValid) begin
      case (execId)
        CMD_UP: begin
          if (curY_q != '0) curY_d = curY_q - Y_ONE;
        end
        CMD_DOWN: begin
          if (curY_q != Y_MAX) curY_d = curY_q + Y_ONE;
        end
        CMD_LEFT: begin
          if (curX_q != '0) curX_d = curX_q - X_ONE;
        end
        CMD_RIGHT: begin
          if (curX_q != X_MAX) curX_d = curX_q + X_ONE;
        end
        CMD_COL: begin
          curColor_d = execX[C_W-1:0];
        end
        CMD_PAL: begin
          palWe_d   = 1'b1;
          palAddr_d = execX[C_W-1:0];
          palData_d = execY;
        end
        CMD_ENT: begin
          fbAddr_d = {curY_q, curX_q};
          fbData_d = curColor_q;
          state_d  = WRITE;
        end
        default: begin
          if (errCnt_q != 8'hFF) errCnt_d = errCnt_q + 8'd1;
        end
      endcase
    end

    busy_d = (state_d == WRITE) || bufValid_d;
  end

  // Datapath registers: cursor, colour, pending buffer, write latches, palette strobe, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      curX_q     <= '0;
      curY_q     <= '0;
      curColor_q <= '0;
      bufValid_q <= 1'b0;
      bufId_q    <= 4'd0;
      bufX_q     <= 7'd0;
      bufY_q     <= 7'd0;
      fbAddr_q   <= '0;
      fbData_q   <= '0;
      palWe_q    <= 1'b0;
      palAddr_q  <= '0;
      palData_q  <= 7'd0;
      busy_q     <= 1'b0;
      dropCnt_q  <= 8'd0;
      errCnt_q   <= 8'd0;
    end else begin
      curX_q     <= curX_d;
      curY_q     <= curY_d;
      curColor_q <= curColor_d;
      bufValid_q <= bufValid_d;
      bufId_q    <= bufId_d;
      bufX_q     <= bufX_d;
      bufY_q     <= bufY_d;
      fbAddr_q   <= fbAddr_d;
      fbData_q   <= fbData_d;
      palWe_q    <= palWe_d;
      palAddr_q  <= palAddr_d;
      palData_q  <= palData_d;
      busy_q     <= busy_d;
      dropCnt_q  <= dropCnt_d;
      errCnt_q   <= errCnt_d;
    end
  end

  assign bus.cur_x     = curX_q;
  assign bus.cur_y     = curY_q;
  assign bus.cur_color = curColor_q;
  assign bus.fb_req    = (state_q == WRITE);
  assign bus.fb_addr   = fbAddr_q;
  assign bus.fb_data   = fbData_q;
  assign bus.pal_we    = palWe_q;
  assign bus.pal_addr  = palAddr_q;
  assign bus.pal_data  = palData_q;
  assign bus.busy      = busy_q;
  assign bus.drop_cnt  = dropCnt_q;
  assign bus.err_cnt   = errCnt_q;

endmodule

// File: tb/tb_paint_cmd_sequencer.sv
// Bench for paint_cmd_sequencer: a directed vector table walking the cursor,
// write, buffering and palette behaviour, hand-written corner sequences, and
// a randomized run compared every cycle against a transaction-level model.
module tb_paint_cmd_sequencer;

  localparam int X_W   = 6;
  localparam int Y_W   = 6;
  localparam int C_W   = 4;
  localparam int X_MAX = (1 << X_W) - 1;
  localparam int Y_MAX = (1 << Y_W) - 1;

  logic clk;
  logic rst;

  paint_cmd_sequencer_if #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W)) bus ();

  paint_cmd_sequencer #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers and a pending-command queue of capacity one.
  typedef struct {
    int id;
    int x;
    int y;
  } cmd_t;

  cmd_t pend[$];
  int   mX, mY, mCol, mReq, mAddr, mData, mWe, mPalA, mPalD, mDrop, mErr;

  typedef struct {
    bit v;   int id;  int x;    int y;    bit ack;
    int eX;  int eY;  int eCol;
    bit eReq; int eAddr; int eData;
    bit eWe; int ePalA; int ePalD;
    bit eBusy; int eDrop; int eErr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkVec(bit v, int id, int x, int y, bit ack,
                                 int eX, int eY, int eCol,
                                 bit eReq, int eAddr, int eData,
                                 bit eWe, int ePalA, int ePalD,
                                 bit eBusy, int eDrop, int eErr);
    vec_t r;
    r.v = v; r.id = id; r.x = x; r.y = y; r.ack = ack;
    r.eX = eX; r.eY = eY; r.eCol = eCol;
    r.eReq = eReq; r.eAddr = eAddr; r.eData = eData;
    r.eWe = eWe; r.ePalA = ePalA; r.ePalD = ePalD;
    r.eBusy = eBusy; r.eDrop = eDrop; r.eErr = eErr;
    return r;
  endfunction

  task automatic cmp(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic modelExec(cmd_t c);
    case (c.id)
      1: mY = (mY > 0) ? mY - 1 : 0;
      2: mY = (mY < Y_MAX) ? mY + 1 : Y_MAX;
      3: mX = (mX > 0) ? mX - 1 : 0;
      4: mX = (mX < X_MAX) ? mX + 1 : X_MAX;
      5: begin
        mAddr = mY * (1 << X_W) + mX;
        mData = mCol;
        mReq  = 1;
      end
      6: mCol = c.x % (1 << C_W);
      7: begin
        mWe   = 1;
        mPalA = c.x % (1 << C_W);
        mPalD = c.y;
      end
      default: mErr = (mErr < 255) ? mErr + 1 : 255;
    endcase
  endtask

  // One clock of the model: execute from the buffer first, then the live command, then buffer or drop.
  task automatic modelStep(bit r, bit v, int id, int x, int y, bit ack);
    cmd_t live;
    bit   wasWriting;
    bit   canLive;
    if (r) begin
      mX = 0; mY = 0; mCol = 0; mReq = 0; mAddr = 0; mData = 0;
      mWe = 0; mPalA = 0; mPalD = 0; mDrop = 0; mErr = 0;
      pend.delete();
      return;
    end
    live.id = id; live.x = x; live.y = y;
    wasWriting = (mReq != 0);
    canLive    = !wasWriting && (pend.size() == 0);
    mWe = 0;
    if (!wasWriting) begin
      if (pend.size() > 0) modelExec(pend.pop_front());
      else if (v) modelExec(live);
    end else if (ack) begin
      mReq = 0;
    end
    if (v && !canLive) begin
      if (pend.size() == 0) pend.push_back(live);
      else mDrop = (mDrop < 255) ? mDrop + 1 : 255;
    end
  endtask

  task automatic applyStimulus(bit r, bit v, int id, int x, int y, bit ack);
    rst           = r;
    bus.cmd_valid = v;
    bus.cmd_id    = 4'(id);
    bus.x         = 7'(x);
    bus.y         = 7'(y);
    bus.fb_ack    = ack;
    @(posedge clk);
    modelStep(r, v, id, x, y, ack);
    #1;
  endtask

  task automatic checkOutput(string tag);
    int busyExp;
    busyExp = (mReq != 0 || pend.size() > 0) ? 1 : 0;
    cmp({tag, " cur_x"},     int'(bus.cur_x),     mX);
    cmp({tag, " cur_y"},     int'(bus.cur_y),     mY);
    cmp({tag, " cur_color"}, int'(bus.cur_color), mCol);
    cmp({tag, " fb_req"},    int'(bus.fb_req),    mReq);
    cmp({tag, " fb_addr"},   int'(bus.fb_addr),   mAddr);
    cmp({tag, " fb_data"},   int'(bus.fb_data),   mData);
    cmp({tag, " pal_we"},    int'(bus.pal_we),    mWe);
    cmp({tag, " pal_addr"},  int'(bus.pal_addr),  mPalA);
    cmp({tag, " pal_data"},  int'(bus.pal_data),  mPalD);
    cmp({tag, " busy"},      int'(bus.busy),      busyExp);
    cmp({tag, " drop_cnt"},  int'(bus.drop_cnt),  mDrop);
    cmp({tag, " err_cnt"},   int'(bus.err_cnt),   mErr);
  endtask

  task automatic checkVec(vec_t e, int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    cmp({t, " cur_x"},     int'(bus.cur_x),     e.eX);
    cmp({t, " cur_y"},     int'(bus.cur_y),     e.eY);
    cmp({t, " cur_color"}, int'(bus.cur_color), e.eCol);
    cmp({t, " fb_req"},    int'(bus.fb_req),    int'(e.eReq));
    cmp({t, " fb_addr"},   int'(bus.fb_addr),   e.eAddr);
    cmp({t, " fb_data"},   int'(bus.fb_data),   e.eData);
    cmp({t, " pal_we"},    int'(bus.pal_we),    int'(e.eWe));
    cmp({t, " pal_addr"},  int'(bus.pal_addr),  e.ePalA);
    cmp({t, " pal_data"},  int'(bus.pal_data),  e.ePalD);
    cmp({t, " busy"},      int'(bus.busy),      int'(e.eBusy));
    cmp({t, " drop_cnt"},  int'(bus.drop_cnt),  e.eDrop);
    cmp({t, " err_cnt"},   int'(bus.err_cnt),   e.eErr);
  endtask

  initial begin
    // Directed vectors from reset: v,id,x,y,ack | x,y,col | req,addr,data | we,pa,pd | busy,drop,err
    tbl.push_back(mkVec(1,4,0,0,0, 1,0,0, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,4,0,0,0, 2,0,0, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,4,0,0,0, 3,0,0, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,2,0,0,0, 3,1,0, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,2,0,0,0, 3,2,0, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,3,0,0,0, 2,2,0, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,3,0,0,0, 1,2,0, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,3,0,0,0, 0,2,0, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,3,0,0,0, 0,2,0, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,3,0,0,0, 0,2,0, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,6,9,0,0, 0,2,9, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,4,0,0,0, 1,2,9, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,4,0,0,0, 2,2,9, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,4,0,0,0, 3,2,9, 0,0,0, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,5,0,0,0, 3,2,9, 1,131,9, 0,0,0, 1,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mkVec(0,0,0,0,0, 3,2,9, 1,131,9, 0,0,0, 1,0,0));
    tbl.push_back(mkVec(0,0,0,0,1, 3,2,9, 0,131,9, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(0,0,0,0,0, 3,2,9, 0,131,9, 0,0,0, 0,0,0));
    tbl.push_back(mkVec(1,7,5,100,0, 3,2,9, 0,131,9, 1,5,100, 0,0,0));
    tbl.push_back(mkVec(0,0,0,0,0, 3,2,9, 0,131,9, 0,5,100, 0,0,0));
    tbl.push_back(mkVec(1,5,0,0,0, 3,2,9, 1,131,9, 0,5,100, 1,0,0));
    tbl.push_back(mkVec(1,4,0,0,0, 3,2,9, 1,131,9, 0,5,100, 1,0,0));
    tbl.push_back(mkVec(1,1,0,0,0, 3,2,9, 1,131,9, 0,5,100, 1,1,0));
    tbl.push_back(mkVec(0,0,0,0,1, 3,2,9, 0,131,9, 0,5,100, 1,1,0));
    tbl.push_back(mkVec(0,0,0,0,0, 4,2,9, 0,131,9, 0,5,100, 0,1,0));
    tbl.push_back(mkVec(1,5,0,0,0, 4,2,9, 1,132,9, 0,5,100, 1,1,0));
    tbl.push_back(mkVec(1,2,0,0,0, 4,2,9, 1,132,9, 0,5,100, 1,1,0));
    tbl.push_back(mkVec(0,0,0,0,1, 4,2,9, 0,132,9, 0,5,100, 1,1,0));
    tbl.push_back(mkVec(1,3,0,0,0, 4,3,9, 0,132,9, 0,5,100, 1,1,0));
    tbl.push_back(mkVec(0,0,0,0,0, 3,3,9, 0,132,9, 0,5,100, 0,1,0));
    tbl.push_back(mkVec(1,5,0,0,0, 3,3,9, 1,195,9, 0,5,100, 1,1,0));
    tbl.push_back(mkVec(0,0,0,0,1, 3,3,9, 0,195,9, 0,5,100, 0,1,0));
    tbl.push_back(mkVec(1,0,0,0,0, 3,3,9, 0,195,9, 0,5,100, 0,1,1));
    tbl.push_back(mkVec(1,8,0,0,0, 3,3,9, 0,195,9, 0,5,100, 0,1,2));
    tbl.push_back(mkVec(1,15,0,0,0, 3,3,9, 0,195,9, 0,5,100, 0,1,3));
    tbl.push_back(mkVec(1,5,0,0,0, 3,3,9, 1,195,9, 0,5,100, 1,1,3));
    tbl.push_back(mkVec(1,6,3,0,0, 3,3,9, 1,195,9, 0,5,100, 1,1,3));
    tbl.push_back(mkVec(0,0,0,0,1, 3,3,9, 0,195,9, 0,5,100, 1,1,3));
    tbl.push_back(mkVec(0,0,0,0,0, 3,3,3, 0,195,9, 0,5,100, 0,1,3));

    // Reset and check every output is cleared.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset");
    cmp("reset busy const", int'(bus.busy), 0);
    cmp("reset fb_req const", int'(bus.fb_req), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(0, tbl[i].v, tbl[i].id, tbl[i].x, tbl[i].y, tbl[i].ack);
      checkVec(tbl[i], i);
      checkOutput($sformatf("vec%0d model", i));
    end

    // 300 invalid commands saturate err_cnt and leave cursor and colour alone.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 1, (i % 3 == 0) ? 0 : 8 + (i % 8), i % 128, 0, 0);
    end
    cmp("errsat err_cnt", int'(bus.err_cnt), 255);
    cmp("errsat cur_x", int'(bus.cur_x), 3);
    cmp("errsat cur_y", int'(bus.cur_y), 3);
    cmp("errsat cur_color", int'(bus.cur_color), 3);
    checkOutput("errsat");

    // Cursor saturates at the far edges.
    for (int i = 0; i < 70; i++) applyStimulus(0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 70; i++) applyStimulus(0, 1, 2, 0, 0, 0);
    cmp("edge cur_x", int'(bus.cur_x), X_MAX);
    cmp("edge cur_y", int'(bus.cur_y), Y_MAX);
    checkOutput("edge");

    // Reset in the middle of a write with the buffer full.
    applyStimulus(0, 1, 5, 0, 0, 0);
    applyStimulus(0, 1, 3, 0, 0, 0);
    cmp("midrst pre fb_req", int'(bus.fb_req), 1);
    cmp("midrst pre fb_addr", int'(bus.fb_addr), Y_MAX * (1 << X_W) + X_MAX);
    applyStimulus(1, 1, 4, 0, 0, 0);
    cmp("midrst fb_req", int'(bus.fb_req), 0);
    cmp("midrst busy", int'(bus.busy), 0);
    cmp("midrst cur_x", int'(bus.cur_x), 0);
    cmp("midrst err_cnt", int'(bus.err_cnt), 0);
    checkOutput("midrst");
    applyStimulus(0, 0, 0, 0, 0, 0);
    cmp("midrst drained cur_x", int'(bus.cur_x), 0);
    applyStimulus(0, 1, 5, 0, 0, 0);
    cmp("postrst fb_req", int'(bus.fb_req), 1);
    cmp("postrst fb_addr", int'(bus.fb_addr), 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    cmp("postrst ack fb_req", int'(bus.fb_req), 0);
    checkOutput("postrst");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, v, a;
      r = ($urandom_range(0, 499) == 0);
      v = ($urandom_range(0, 99) < 60);
      a = ($urandom_range(0, 99) < 35);
      applyStimulus(r, v, $urandom_range(0, 9), $urandom_range(0, 127),
                    $urandom_range(0, 127), a);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/paint_cmd_sequencer.md
# paint_cmd_sequencer

Executes the decoded host commands (`cmd_valid`/`cmd_id`/`x`/`y` from the ASCII command decoder) against the paint canvas. Owns the cursor position and current colour, sequences single-pixel framebuffer writes over a req/ack handshake, and issues palette-RAM writes. It sits between the HID command decoder and the framebuffer/palette memories. Because the decoder has no back-pressure, a one-entry pending buffer and a drop counter absorb commands that arrive while a write is in flight.

## Interface
- `X_W`, 6: cursor X width; canvas columns = 2^X_W
- `Y_W`, 6: cursor Y width; canvas rows = 2^Y_W
- `C_W`, 4: colour-index width
- `clk` input 1: single clock, all logic on rising edge
- `rst` input 1: synchronous, active-high reset
- `cmd_valid` input 1: one-cycle command strobe
- `cmd_id` input 4: 1=UP 2=DOWN 3=LEFT 4=RIGHT 5=ENT 6=COL 7=PAL, others invalid
- `x` input 7: argument 1
- `y` input 7: argument 2
- `cur_x` output X_W: cursor column
- `cur_y` output Y_W: cursor row
- `cur_color` output C_W: current colour index
- `fb_req` output 1: framebuffer write request
- `fb_addr` output X_W+Y_W: `{cur_y, cur_x}` latched at request
- `fb_data` output C_W: colour latched at request
- `fb_ack` input 1: framebuffer accepted write (sampled only while `fb_req`=1)
- `pal_we` output 1: one-cycle palette write strobe
- `pal_addr` output C_W: `x[C_W-1:0]`
- `pal_data` output 7: `y`
- `busy` output 1: state is WRITE or pending buffer occupied
- `drop_cnt` output 8: saturating count of dropped commands
- `err_cnt` output 8: saturating count of invalid `cmd_id`

## Operation
- States: IDLE, WRITE.
- Command source each cycle: pending buffer if occupied and state IDLE, else the live `cmd_valid` input. The buffer always wins over the live input.
- Commands execute only in IDLE:
  - UP: `cur_y`-1, saturating at 0.
  - DOWN: `cur_y`+1, saturating at 2^Y_W-1.
  - LEFT: `cur_x`-1, saturating at 0.
  - RIGHT: `cur_x`+1, saturating at 2^X_W-1.
  - COL: `cur_color` <= `x[C_W-1:0]`.
  - PAL: `pal_we`=1 for one cycle with `pal_addr`/`pal_data`.
  - ENT: latch `fb_addr`/`fb_data`, go to WRITE.
  - Invalid id (0, 8-15): `err_cnt`+1, no other effect.
- WRITE: `fb_req`=1 with `fb_addr`/`fb_data` stable. On the cycle `fb_ack`=1, return to IDLE.
- `cmd_valid` while not able to execute (state WRITE, or buffer draining this cycle):
  - Buffer empty or being drained this cycle: capture into buffer.
  - Otherwise: discard and `drop_cnt`+1.
- Counters saturate at 255, no wrap.
- COL issued after ENT does not alter an in-flight `fb_data`.

## Timing
- Reset values:
  - all outputs 0 (`cur_x`, `cur_y`, `cur_color`, `fb_req`, `fb_addr`, `fb_data`, `pal_we`, `pal_addr`, `pal_data`, `busy`, `drop_cnt`, `err_cnt`).
  - state IDLE, buffer empty.
  - Reset during WRITE drops `fb_req` the next cycle and discards the buffer.
- Move/COL/PAL strobe at cycle N: result visible at N+1 (`pal_we` high during N+1 only).
- ENT strobe at cycle N in IDLE: `fb_req`=1 from N+1. If `fb_ack`=1 at cycle M, `fb_req`=0 at M+1. Minimum occupancy is 1 cycle (ack at N+1).
- Buffered command executes in the first IDLE cycle (M+1), taking effect at M+2.
- A live `cmd_valid` at M+1 is buffered, not dropped.
- `busy` is registered and reflects state and buffer after the current edge.

## Test plan
- After reset: RIGHT×3, DOWN×2 -> `cur_x`=3, `cur_y`=2. Then LEFT×5 -> `cur_x`=0 (saturated).
- COL `x`=9, then ENT at (3,2) -> `fb_req` next cycle with `fb_addr`=`{6'd2,6'd3}`, `fb_data`=9. Holding `fb_ack` low 4 cycles keeps `fb_req` high and stable. Ack -> `fb_req` low next cycle.
- During WRITE send RIGHT then UP before ack:
  - RIGHT is buffered; UP increments `drop_cnt` to 1.
  - After ack: `cur_x`+1 two cycles later, `cur_y` unchanged.
- PAL `x`=5, `y`=100 -> exactly one cycle of `pal_we` with `pal_addr`=5, `pal_data`=100.
- `cmd_id`=0 ×300 -> `err_cnt`=255; cursor and colour unchanged.
- Assert `rst` mid-WRITE with buffer full -> next cycle all outputs 0 and `busy`=0. ENT afterwards works normally.
